// File: rtl/pc_target_table.sv
// Programmable branch-target table: run-time written entries, absolute or PC-relative,
// with a one-cycle registered lookup that falls through to pc+1 on unprogrammed entries.
module pc_target_table #(
    parameter int D     = 10,
    parameter int AW    = 4,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          lk_valid,
    input  logic [AW-1:0] lk_addr,
    input  logic [D-1:0]  lk_pc,
    output logic          tgt_valid,
    output logic [D-1:0]  target,
    output logic          tgt_hit,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_rel,
    output logic          busy
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     clr_ptr_q;
    logic [DEPTH-1:0]  valid_q;
    logic [D-1:0]      data_q [DEPTH];
    logic              rel_q  [DEPTH];

    logic              tgt_valid_q;
    logic [D-1:0]      target_q;
    logic              tgt_hit_q;

    logic              wr_fire_s;
    logic              bypass_s;
    logic              hit_d;
    logic [D-1:0]      sel_data_s;
    logic              sel_rel_s;
    logic [D-1:0]      target_d;

    assign wr_fire_s = wr_valid && (state_q == READY);
    assign bypass_s  = wr_fire_s && (wr_addr == lk_addr);

    // Lookup resolution; a same-cycle write to the looked-up index is forwarded.
    always_comb begin
        hit_d      = 1'b0;
        sel_data_s = data_q[lk_addr];
        sel_rel_s  = rel_q[lk_addr];
        target_d   = lk_pc + {{(D-1){1'b0}}, 1'b1};
        if (state_q == CLEAR) begin
            hit_d = 1'b0;
        end else if (bypass_s) begin
            hit_d      = 1'b1;
            sel_data_s = wr_data;
            sel_rel_s  = wr_rel;
        end else begin
            hit_d = valid_q[lk_addr];
        end
        if (!hit_d) begin
            target_d = lk_pc + {{(D-1){1'b0}}, 1'b1};
        end else if (sel_rel_s) begin
            target_d = lk_pc + sel_data_s;
        end else begin
            target_d = sel_data_s;
        end
    end

    // Control FSM, per-entry valid bits and registered lookup result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= {AW{1'b0}};
            tgt_valid_q <= 1'b0;
            target_q    <= {D{1'b0}};
            tgt_hit_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    valid_q[clr_ptr_q] <= 1'b0;
                    clr_ptr_q          <= clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                    if (clr_ptr_q == {AW{1'b1}}) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (wr_fire_s) begin
                        valid_q[wr_addr] <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= {AW{1'b0}};
                end
            endcase
            tgt_valid_q <= lk_valid;
            if (lk_valid) begin
                target_q  <= target_d;
                tgt_hit_q <= hit_d;
            end
        end
    end

    // Entry payload storage; contents are meaningful only while the valid bit is set.
    always_ff @(posedge clk) begin
        if (reset_n && wr_fire_s) begin
            data_q[wr_addr] <= wr_data;
            rel_q[wr_addr]  <= wr_rel;
        end
    end

    assign tgt_valid = tgt_valid_q;
    assign target    = target_q;
    assign tgt_hit   = tgt_hit_q;
    assign wr_ready  = (state_q == READY);
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_pc_target_table.sv
// Directed self-checking bench for pc_target_table: clear sweep, abs/rel hits, bypass,
// reset during READY with writes held, and back-to-back lookups.
module tb_pc_target_table;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lk_valid;
    logic [3:0] lk_addr;
    logic [9:0] lk_pc;
    logic       tgt_valid;
    logic [9:0] target;
    logic       tgt_hit;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic       wr_rel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pc_target_table dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lk_valid  (lk_valid),
        .lk_addr   (lk_addr),
        .lk_pc     (lk_pc),
        .tgt_valid (tgt_valid),
        .target    (target),
        .tgt_hit   (tgt_hit),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic v, input logic [9:0] t, input logic h);
        check({tag, "_valid"}, {31'd0, tgt_valid}, {31'd0, v});
        check({tag, "_target"}, {22'd0, target}, {22'd0, t});
        check({tag, "_hit"}, {31'd0, tgt_hit}, {31'd0, h});
    endtask

    task automatic do_write(input logic [3:0] a, input logic [9:0] d, input logic r);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_rel   = r;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        lk_valid = 1'b0;
        lk_addr  = 4'd0;
        lk_pc    = 10'd0;
        wr_valid = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 10'd0;
        wr_rel   = 1'b0;

        // 1: reset and clear sweep
        tick();
        check_result("reset", 1'b0, 10'd0, 1'b0);
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("clear_busy", {31'd0, busy}, 32'd1);
            check("clear_wr_ready", {31'd0, wr_ready}, 32'd0);
            if (i == 3) check_result("clear_lookup", 1'b1, 10'd41, 1'b0);
            if (i == 4) check_result("clear_hold", 1'b0, 10'd41, 1'b0);
            lk_valid = (i == 2);
            lk_addr  = 4'd3;
            lk_pc    = 10'd40;
            tick();
        end
        lk_valid = 1'b0;
        check("ready_busy", {31'd0, busy}, 32'd0);
        check("ready_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 2: absolute entry and a miss
        do_write(4'd2, 10'd81, 1'b0);
        lk_valid = 1'b1; lk_addr = 4'd2; lk_pc = 10'd0;
        tick();
        check_result("abs_hit", 1'b1, 10'd81, 1'b1);
        lk_addr = 4'd4; lk_pc = 10'd0;
        tick();
        check_result("miss", 1'b1, 10'd1, 1'b0);
        lk_valid = 1'b0;

        // 3: relative entry with wrap
        do_write(4'd5, 10'h3FB, 1'b1);
        lk_valid = 1'b1; lk_addr = 4'd5; lk_pc = 10'd4;
        tick();
        check_result("rel_wrap", 1'b1, 10'd1023, 1'b1);
        lk_pc = 10'd20;
        tick();
        check_result("rel_neg", 1'b1, 10'd15, 1'b1);

        // 4: same-cycle write and lookup bypass
        lk_addr = 4'd7; lk_pc = 10'd9;
        do_write(4'd7, 10'd60, 1'b0);
        check_result("bypass", 1'b1, 10'd60, 1'b1);
        lk_pc = 10'd0;
        tick();
        check_result("after_bypass", 1'b1, 10'd60, 1'b1);

        // 6: back-to-back alternating lookups
        for (int k = 0; k < 8; k++) begin
            lk_valid = 1'b1;
            lk_addr  = (k % 2 == 0) ? 4'd2 : 4'd5;
            lk_pc    = 10'd100 + 10'(k);
            tick();
            check_result("b2b", 1'b1, (k % 2 == 0) ? 10'd81 : (10'd95 + 10'(k)), 1'b1);
        end
        lk_valid = 1'b0;
        tick();
        check_result("b2b_idle", 1'b0, 10'd102, 1'b1);

        // 5: program idx0..3, reset with writes held through the sweep
        for (int i = 0; i < 4; i++) do_write(4'(i), 10'd200 + 10'(i), 1'b0);
        reset_n  = 1'b0;
        wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 10'd5; wr_rel = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd0; lk_pc = 10'd3;
        tick();
        reset_n = 1'b1;
        check_result("rst2", 1'b0, 10'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            check("rst2_busy", {31'd0, busy}, 32'd1);
            check("rst2_wr_ready", {31'd0, wr_ready}, 32'd0);
            if (i == 2) check_result("rst2_clear_miss", 1'b1, 10'd8, 1'b0);
            lk_valid = (i == 1);
            lk_addr  = 4'd2;
            lk_pc    = 10'd7;
            tick();
        end
        wr_valid = 1'b0;
        check("rst2_ready", {31'd0, wr_ready}, 32'd1);
        lk_valid = 1'b1; lk_addr = 4'd1; lk_pc = 10'd1023;
        tick();
        check_result("rst2_idx1", 1'b1, 10'd0, 1'b0);
        lk_addr = 4'd2; lk_pc = 10'd50;
        tick();
        check_result("rst2_idx2", 1'b1, 10'd51, 1'b0);
        lk_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
